// File: rtl/tdm_demux4_rx_pkg.sv
// Shared constants for the TDM 4-channel receiver: FSM state encodings
// and the default slot width.
package tdm_demux4_rx_pkg;

  // Bits per channel slot when the parent does not override it.
  localparam int SLOT_BITS_DEF = 4;

  // Receiver framing states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

endpackage : tdm_demux4_rx_pkg

// File: rtl/tdm_demux4_rx_demux4.sv
// 1-to-4 demultiplexer: routes a single strobe onto one of four outputs
// selected by a 2-bit index. The receiver uses it to turn "slot finished"
// into per-channel staging-register load enables.
module tdm_demux4_rx_demux4 (
  input  logic       d_i,
  input  logic [1:0] s_i,
  output logic [3:0] y_o
);

  // Decode the select index and steer the strobe onto exactly one output.
  always_comb begin
    y_o = 4'b0000;
    case (s_i)
      2'd0:    y_o = {3'b000, d_i};
      2'd1:    y_o = {2'b00, d_i, 1'b0};
      2'd2:    y_o = {1'b0, d_i, 2'b00};
      2'd3:    y_o = {d_i, 3'b000};
      default: y_o = 4'b0000;
    endcase
  end

endmodule : tdm_demux4_rx_demux4

// File: rtl/tdm_demux4_rx.sv
// Framed serial TDM receiver. A sync-qualified bit starts a frame of four
// slots; each slot is deserialised MSB first into a staging word, and when
// the last bit of slot 3 arrives all four channel words are published
// together with a one-cycle frame_valid strobe. A sync seen while a frame is
// in progress raises sync_err and restarts framing on that same bit.
module tdm_demux4_rx
  import tdm_demux4_rx_pkg::*;
#(
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 d,
  output logic [SLOT_BITS-1:0] y0,
  output logic [SLOT_BITS-1:0] y1,
  output logic [SLOT_BITS-1:0] y2,
  output logic [SLOT_BITS-1:0] y3,
  output logic                 frame_valid,
  output logic                 sync_err,
  output logic [1:0]           sel
);

  localparam int              CW       = $clog2(SLOT_BITS);
  localparam logic [CW-1:0]   LAST_BIT = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};

  state_e               state_q;
  logic [CW-1:0]        bitcnt_q;
  logic [1:0]           sel_q;
  // Only SLOT_BITS-1 bits need storing: the final bit of a slot is taken
  // straight from d when the word completes.
  logic [SLOT_BITS-2:0] shift_q;
  logic [SLOT_BITS-1:0] staging_q [3];
  logic [SLOT_BITS-1:0] y_q       [4];
  logic                 frame_valid_q;
  logic                 sync_err_q;

  logic [SLOT_BITS-1:0] word_d;
  logic                 slot_done_s;
  logic [3:0]           slot_load_s;

  // Form the word as it would look with the current bit appended, and flag
  // the bit that closes a slot (only a non-sync accepted bit can do that).
  always_comb begin
    word_d      = {shift_q, d};
    slot_done_s = 1'b0;
    if ((state_q == ST_RECV) && en && !sync && (bitcnt_q == LAST_BIT)) begin
      slot_done_s = 1'b1;
    end else begin
      slot_done_s = 1'b0;
    end
  end

  tdm_demux4_rx_demux4 u_demux4 (
    .d_i (slot_done_s),
    .s_i (sel_q),
    .y_o (slot_load_s)
  );

  // Capture completed slot 0..2 words; slot 3 goes straight to the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        staging_q[k] <= {SLOT_BITS{1'b0}};
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (slot_load_s[k]) begin
          staging_q[k] <= word_d;
        end
      end
    end
  end

  // Framing FSM with bit/slot counters, shift register and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= CNT_ZERO;
      sel_q         <= 2'd0;
      shift_q       <= {(SLOT_BITS-1){1'b0}};
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        y_q[k] <= {SLOT_BITS{1'b0}};
      end
    end else begin
      // Status strobes are single-cycle unless re-armed below.
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Bits without sync are dropped while hunting for a frame start.
          if (en && sync) begin
            shift_q  <= word_d[SLOT_BITS-2:0];
            bitcnt_q <= CNT_ONE;
            sel_q    <= 2'd0;
            state_q  <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (en) begin
            if (sync) begin
              // Misplaced sync: abandon the partial frame and restart on
              // this bit as bit 0 of slot 0.
              sync_err_q <= 1'b1;
              shift_q    <= word_d[SLOT_BITS-2:0];
              bitcnt_q   <= CNT_ONE;
              sel_q      <= 2'd0;
            end else if (slot_load_s[3]) begin
              // Last bit of slot 3: publish the whole frame at once.
              y_q[0]        <= staging_q[0];
              y_q[1]        <= staging_q[1];
              y_q[2]        <= staging_q[2];
              y_q[3]        <= word_d;
              frame_valid_q <= 1'b1;
              bitcnt_q      <= CNT_ZERO;
              sel_q         <= 2'd0;
              state_q       <= ST_IDLE;
            end else if (slot_done_s) begin
              bitcnt_q <= CNT_ZERO;
              sel_q    <= sel_q + 2'd1;
            end else begin
              shift_q  <= word_d[SLOT_BITS-2:0];
              bitcnt_q <= bitcnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          bitcnt_q <= CNT_ZERO;
          sel_q    <= 2'd0;
        end
      endcase
    end
  end

  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];
  assign y3          = y_q[3];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign sel         = sel_q;

endmodule : tdm_demux4_rx
